// File: rtl/tr_adc_reader_pkg.sv
// Shared types and frame geometry for the tracking-chain ADC reader.
package tr_adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int DATA_W     = 12;
  localparam int AVG_N      = 4;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_e;

  // A frame is only trustworthy when the ADC's leading pad bits read back as zero.
  function automatic logic lead_ok(input logic [FRAME_BITS-1:0] w);
    return w[FRAME_BITS-1 -: LEAD_BITS] == '0;
  endfunction

endpackage

// File: rtl/tr_adc_reader_if.sv
// SPI pin bundle between the reader (master) and the ADC (slave).
interface tr_adc_reader_if;

  logic adc_cs_n;
  logic adc_sclk;
  logic adc_sdo;

  modport master (output adc_cs_n, output adc_sclk, input adc_sdo);
  modport slave  (input adc_cs_n, input adc_sclk, output adc_sdo);

endinterface

// File: rtl/tr_adc_reader_sclk_div.sv
// SCLK half-period divider: toggle/rise strobes and bit position while run_i is high.
// Counters sit at zero whenever run_i is low, so each frame starts from a clean phase.
module adc_sclk_div
  import tr_adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  output logic                 toggle_o,
  output logic                 rise_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o,
  output logic                 last_bit_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 phase_q, phase_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 toggle;

  assign toggle = run_i && (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (!run_i) begin
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
    end else if (toggle) begin
      div_d   = '0;
      phase_d = ~phase_q;
      if (phase_q) bit_d = bit_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  assign toggle_o   = toggle;
  assign rise_o     = toggle && !phase_q;
  assign bit_cnt_o  = bit_q;
  assign last_bit_o = toggle && phase_q && (bit_q == BIT_CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/tr_adc_reader.sv
// Free-running SPI ADC reader: one 12-bit sample per 34*CLK_DIV+CONV_GAP cycle frame.
// Optional ADC_AVG_EN: issue the truncated mean of every AVG_N good frames instead.
module tr_adc_reader
  import tr_adc_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CONV_GAP = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  tr_adc_reader_if.master       spi,
  output logic [DATA_W-1:0]     x,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TMR_MAX = (CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // The sync-delay compensation leaves no slack before the result edge at CLK_DIV=1.
  if (CLK_DIV < 2) begin : g_clk_div_chk
    $error("tr_adc_reader: CLK_DIV must be >= 2");
  end

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   cs_n_q, sclk_q, sclk_d;
  logic                   sdo_s1_q, sdo_s2_q;
  logic [1:0]             rise_pipe_q;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic [DATA_W-1:0]      x_q, x_d;
  logic                   dv_q, dv_d, fe_q, fe_d, busy_q;
  logic                   toggle, rise, last_bit, frame_done;
  logic [BIT_CNT_W-1:0]   bit_cnt;
`ifdef ADC_AVG_EN
  localparam int ACC_W = DATA_W + $clog2(AVG_N);
  logic [ACC_W-1:0]         acc_q, acc_d, acc_sum;
  logic [$clog2(AVG_N)-1:0] avg_cnt_q, avg_cnt_d;
`endif

  adc_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .run_i      (state_q == SHIFT),
    .toggle_o   (toggle),
    .rise_o     (rise),
    .bit_cnt_o  (bit_cnt),
    .last_bit_o (last_bit)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    case (state_q)
      IDLE:     if (enable) state_d = CS_SETUP;
      CS_SETUP: if (tmr_q == TMR_W'(CLK_DIV - 1)) state_d = SHIFT;
      SHIFT:    if (last_bit) state_d = CS_HOLD;
      CS_HOLD:  if (tmr_q == TMR_W'(CLK_DIV - 1)) state_d = GAP;
      GAP:      if (tmr_q == TMR_W'(CONV_GAP - 1)) state_d = enable ? CS_SETUP : IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;

    sclk_d = 1'b1;
    if (state_d == SHIFT) sclk_d = (state_q != SHIFT) ? 1'b0 : (toggle ? ~sclk_q : sclk_q);
  end

  assign frame_done = (state_q == CS_HOLD) && (state_d == GAP);

  always_comb begin
    x_d  = x_q;
    dv_d = 1'b0;
    fe_d = 1'b0;
`ifdef ADC_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + ACC_W'(shreg_q[DATA_W-1:0]);
`endif
    if (frame_done) begin
      if (lead_ok(shreg_q)) begin
`ifdef ADC_AVG_EN
        if (avg_cnt_q == $bits(avg_cnt_q)'(AVG_N - 1)) begin
          x_d       = acc_sum[ACC_W-1 -: DATA_W];
          dv_d      = 1'b1;
          acc_d     = '0;
          avg_cnt_d = '0;
        end else begin
          acc_d     = acc_sum;
          avg_cnt_d = avg_cnt_q + 1'b1;
        end
`else
        x_d  = shreg_q[DATA_W-1:0];
        dv_d = 1'b1;
`endif
      end else begin
        fe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      sdo_s1_q    <= 1'b0;
      sdo_s2_q    <= 1'b0;
      rise_pipe_q <= '0;
      shreg_q     <= '0;
      x_q         <= '0;
      dv_q        <= 1'b0;
      fe_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADC_AVG_EN
      acc_q       <= '0;
      avg_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cs_n_q      <= !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
      sclk_q      <= sclk_d;
      sdo_s1_q    <= spi.adc_sdo;
      sdo_s2_q    <= sdo_s1_q;
      // Shift two cycles after the rise so the synchronized bit is the one present at the edge.
      rise_pipe_q <= {rise_pipe_q[0], rise};
      if (rise_pipe_q[1]) shreg_q <= {shreg_q[FRAME_BITS-2:0], sdo_s2_q};
      x_q         <= x_d;
      dv_q        <= dv_d;
      fe_q        <= fe_d;
      busy_q      <= (state_d != IDLE);
`ifdef ADC_AVG_EN
      acc_q       <= acc_d;
      avg_cnt_q   <= avg_cnt_d;
`endif
    end
  end

  a_last_bit_pos: assert property (@(posedge clk) disable iff (rst)
    last_bit |-> (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)));

  assign spi.adc_cs_n = cs_n_q;
  assign spi.adc_sclk = sclk_q;
  assign x            = x_q;
  assign data_valid   = dv_q;
  assign frame_err    = fe_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tr_adc_reader.sv
// Bench for tr_adc_reader: SDO word model plus per-frame result scoreboard and directed scenarios.
module tb_tr_adc_reader;
  import tr_adc_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CONV_GAP = 10;
  localparam int LAT      = 34 * CLK_DIV;
  localparam int PERIOD   = LAT + CONV_GAP;
  localparam int S_CS = 0, S_DV = 1, S_FE = 2, S_BUSY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] x;
  logic        data_valid, frame_err, busy;

  tr_adc_reader_if spi ();

  tr_adc_reader #(.CLK_DIV(CLK_DIV), .CONV_GAP(CONV_GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .spi        (spi),
    .x          (x),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial forever #10 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_at_edge = rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_CS:    return spi.adc_cs_n;
      S_DV:    return data_valid;
      S_FE:    return frame_err;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int limit,
                          input string name, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (sig(sel) === val) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_total++;
      $display("FAIL %s: no event within %0d cycles, expected one", name, limit);
    end
  endtask

  // ADC + scoreboard: serve sdo_word MSB first on falling sclk, judge each completed frame.
  logic [15:0] sdo_word = 16'h0000;
  logic [15:0] frame_word;
  logic [11:0] exp_x = 12'h000;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  bit          model_on = 1'b0, in_frame = 1'b0, exp_dv, exp_fe;
  int          frame_start = 0, rises = 0, bitn = 0, acc = 0, navg = 0;

  initial begin
    spi.adc_sdo = 1'b1;
    forever begin
      @(negedge clk);
      exp_dv = 1'b0;
      exp_fe = 1'b0;
      if (rst_at_edge) begin
        model_on = 1'b1;
        exp_x    = 12'h000;
        in_frame = 1'b0;
        rises    = 0;
        acc      = 0;
        navg     = 0;
      end
      if (model_on) begin
        if (!spi.adc_cs_n && prev_cs) begin
          in_frame    = 1'b1;
          frame_start = cyc;
          rises       = 0;
          bitn        = 0;
          frame_word  = sdo_word;
        end
        if (in_frame && !spi.adc_cs_n) begin
          if (prev_sclk && !spi.adc_sclk && bitn < 16) begin
            spi.adc_sdo = frame_word[15-bitn];
            bitn++;
          end
          if (!prev_sclk && spi.adc_sclk) rises++;
        end
        if (spi.adc_cs_n && !prev_cs && in_frame) begin
          chk("frame_latency", cyc - frame_start, LAT);
          chk("sclk_rises", rises, 16);
          if (frame_word[15:12] == 4'h0) begin
`ifdef ADC_AVG_EN
            acc += int'(frame_word[11:0]);
            navg++;
            if (navg == AVG_N) begin
              exp_x  = 12'(acc / 4);
              exp_dv = 1'b1;
              acc    = 0;
              navg   = 0;
            end
`else
            exp_x  = frame_word[11:0];
            exp_dv = 1'b1;
`endif
          end else begin
            exp_fe = 1'b1;
          end
          in_frame    = 1'b0;
          spi.adc_sdo = 1'b1;
        end
        chk("data_valid", 32'(data_valid), 32'(exp_dv));
        chk("frame_err", 32'(frame_err), 32'(exp_fe));
        chk("x", 32'(x), 32'(exp_x));
        if (spi.adc_cs_n) chk("sclk_idle_high", 32'(spi.adc_sclk), 1);
      end
      prev_cs   = spi.adc_cs_n;
      prev_sclk = spi.adc_sclk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, lows;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(spi.adc_cs_n), 1);
    chk("rst_sclk", 32'(spi.adc_sclk), 1);
    chk("rst_x", 32'(x), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_fe", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
`ifndef ADC_AVG_EN
    sdo_word = 16'h0ABC;
    enable   = 1'b1;
    wait_for(S_CS, 1'b0, 20, "first_cs_fall", t0);
    chk("busy_in_frame", 32'(busy), 1);
    wait_for(S_DV, 1'b1, 200, "dv_abc", t1);
    chk("lat_abc", t1 - t0, 136);
    chk("x_abc", 32'(x), 32'h0ABC);
    sdo_word = 16'h8123;
    wait_for(S_CS, 1'b0, 40, "cs_fall_2", t2);
    chk("frame_period", t2 - t0, PERIOD);
    wait_for(S_FE, 1'b1, 200, "fe_8123", t1);
    chk("lat_8123", t1 - t2, 136);
    chk("dv_on_err", 32'(data_valid), 0);
    chk("x_hold_on_err", 32'(x), 32'h0ABC);
    sdo_word = 16'h0FFF;
    wait_for(S_DV, 1'b1, 200, "dv_fff", t1);
    chk("x_fff", 32'(x), 32'h0FFF);
    sdo_word = 16'h0000;
    wait_for(S_DV, 1'b1, 200, "dv_000", t1);
    chk("x_000", 32'(x), 32'h0000);
    // enable dropped part-way through a frame
    sdo_word = 16'h0123;
    wait_for(S_CS, 1'b0, 40, "cs_fall_drop", t0);
    repeat (49) @(negedge clk);
    enable = 1'b0;
    wait_for(S_DV, 1'b1, 200, "dv_123", t1);
    chk("lat_123", t1 - t0, 136);
    chk("x_123", 32'(x), 32'h0123);
    repeat (10) @(negedge clk);
    chk("busy_after_drop", 32'(busy), 0);
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!spi.adc_cs_n) lows++;
    end
    chk("cs_stays_high", lows, 0);
    // reset part-way through a frame
    sdo_word = 16'h0555;
    enable   = 1'b1;
    wait_for(S_CS, 1'b0, 20, "cs_fall_rst", t0);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", 32'(spi.adc_cs_n), 1);
    chk("midrst_sclk", 32'(spi.adc_sclk), 1);
    chk("midrst_x", 32'(x), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    wait_for(S_CS, 1'b0, 20, "cs_fall_after_rst", t2);
    wait_for(S_DV, 1'b1, 200, "dv_555", t1);
    chk("lat_555", t1 - t2, 136);
    chk("x_555", 32'(x), 32'h0555);
`else
    sdo_word = 16'd100;
    enable   = 1'b1;
    wait_for(S_CS, 1'b0, 20, "avg_cs_fall", t0);
    repeat (5) @(negedge clk);
    sdo_word = 16'd101;
    wait_for(S_CS, 1'b1, 200, "avg_cs_rise_1", t1);
    wait_for(S_CS, 1'b0, 40, "avg_cs_fall_2", t1);
    repeat (5) @(negedge clk);
    sdo_word = 16'd102;
    wait_for(S_CS, 1'b1, 200, "avg_cs_rise_2", t1);
    wait_for(S_CS, 1'b0, 40, "avg_cs_fall_3", t1);
    repeat (5) @(negedge clk);
    sdo_word = 16'd104;
    wait_for(S_DV, 1'b1, 4 * PERIOD, "avg_dv", t1);
    chk("avg_lat", t1 - t0, 3 * PERIOD + LAT);
    chk("avg_x", 32'(x), 101);
    enable = 1'b0;
`endif
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
